mem_store_unit: RTL

Write-side port for the 1 MB low-order 4-way byte-interleaved memory: four 8-bit banks of 2^18 rows each, mapped at 0x8000_0000. It is the counterpart of the instruction-fetch read path. It accepts RV64 store requests (sb/sh/sw/sd, any alignment) over a valid/ready handshake, splits them into per-row bank writes with byte enables, and returns a completion or error response.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/store_lane_align.sv | 31 +++
 rtl/mem_store_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the interleaved memory store path.
package mem_pkg;

    // Store access size as encoded on req_size
    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    localparam logic [63:0] MEM_BASE = 64'h8000_0000;
    localparam int          ROW_W    = 18;
    localparam int          NBANK    = 4;

    // A misaligned doubleword touches at most three rows
    localparam int MAX_BEATS = 3;
    localparam int MASK_W    = NBANK * MAX_BEATS;
    localparam int LANE_W    = 8 * MASK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/store_lane_align.sv
// Places right-aligned store data onto the byte lanes of up to three
// consecutive rows and derives the matching byte-enable mask and beat count.
module store_lane_align
    import mem_pkg::*;
(
    input  logic [63:0]       data,
    input  logic [1:0]        off,
    input  size_e             size,
    output logic [LANE_W-1:0] lane,
    output logic [MASK_W-1:0] mask,
    output logic [1:0]        nbeat
);

    logic [3:0]        nbytes;
    logic [3:0]        span;
    logic [LANE_W-1:0] byte_keep;

    // Shift data and mask by the in-row offset; zero every byte not written
    always_comb begin
        nbytes = 4'd1 << size;
        mask   = ((MASK_W'(1) << nbytes) - MASK_W'(1)) << off;
        for (int b = 0; b < MASK_W; b++) begin
            byte_keep[8*b +: 8] = {8{mask[b]}};
        end
        lane  = ({{(LANE_W-64){1'b0}}, data} << {off, 3'b000}) & byte_keep;
        // ceil((off + nbytes) / 4); at most 3 for a misaligned doubleword
        span  = {2'b00, off} + nbytes + 4'd3;
        nbeat = 2'(span >> 2);
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store port for the 4-way byte-interleaved memory: accepts one store,
// range checks it, issues one registered bank-write beat per row touched,
// then holds a completion/error response until it is taken.
module mem_store_unit
    import mem_pkg::*;
#(
    parameter logic [63:0] BASE  = MEM_BASE,
    parameter int          ROW_W = mem_pkg::ROW_W
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_addr,
    input  logic [63:0]      req_data,
    input  logic [1:0]       req_size,
    output logic [NBANK-1:0] wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [31:0]      wr_data,
    output logic             resp_valid,
    output logic             resp_err,
    input  logic             resp_ready
);

    state_e            state, state_d;
    logic [1:0]        beat, beat_d, beat_nx, nbeat_q;
    logic [LANE_W-1:0] lane_q, al_lane;
    logic [MASK_W-1:0] mask_q, al_mask;
    logic [1:0]        al_nbeat;
    logic [ROW_W-1:0]  row0_q, row0_new;
    logic              err_q;

    logic [3:0]        nbytes;
    logic [64:0]       last_byte, limit;
    logic              range_err, load;

    logic [NBANK-1:0]  wr_en_d;
    logic [ROW_W-1:0]  wr_row_d;
    logic [31:0]       wr_data_d;

    store_lane_align u_align (
        .data  (req_data),
        .off   (req_addr[1:0]),
        .size  (size_e'(req_size)),
        .lane  (al_lane),
        .mask  (al_mask),
        .nbeat (al_nbeat)
    );

    // Window check on the incoming request; 65-bit math so addresses near
    // the top of the 64-bit space cannot wrap back into the window
    always_comb begin
        nbytes    = 4'd1 << req_size;
        last_byte = {1'b0, req_addr} + {61'd0, nbytes} - 65'd1;
        limit     = {1'b0, BASE} + (65'd1 << (ROW_W + 2));
        range_err = (req_addr < BASE) || (last_byte >= limit);
        row0_new  = ROW_W'((req_addr - BASE) >> 2);
    end

    assign beat_nx    = beat + 2'd1;
    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next state and next beat outputs; beat 0 comes straight from the
    // aligner so it is on the bank port the cycle after acceptance
    always_comb begin
        state_d   = state;
        beat_d    = beat;
        load      = 1'b0;
        wr_en_d   = '0;
        wr_row_d  = '0;
        wr_data_d = '0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    load = 1'b1;
                    if (range_err) begin
                        state_d = RESP;
                    end else begin
                        state_d   = WRITE;
                        beat_d    = 2'd0;
                        wr_en_d   = al_mask[NBANK-1:0];
                        wr_row_d  = row0_new;
                        wr_data_d = al_lane[31:0];
                    end
                end
            end
            WRITE: begin
                if (beat_nx < nbeat_q) begin
                    beat_d    = beat_nx;
                    wr_en_d   = mask_q[{beat_nx, 2'b00} +: NBANK];
                    wr_row_d  = row0_q + ROW_W'(beat_nx);
                    wr_data_d = lane_q[{beat_nx, 5'b00000} +: 32];
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched request, beat counter and registered bank-write outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            beat    <= '0;
            nbeat_q <= '0;
            lane_q  <= '0;
            mask_q  <= '0;
            row0_q  <= '0;
            err_q   <= 1'b0;
            wr_en   <= '0;
            wr_row  <= '0;
            wr_data <= '0;
        end else begin
            beat    <= beat_d;
            wr_en   <= wr_en_d;
            wr_row  <= wr_row_d;
            wr_data <= wr_data_d;
            if (load) begin
                lane_q  <= al_lane;
                mask_q  <= al_mask;
                row0_q  <= row0_new;
                nbeat_q <= al_nbeat;
                err_q   <= range_err;
            end
        end
    end

endmodule
